// File: rtl/data_cache_tag_assoc.sv
// data_cache_tag_assoc
//   N-way set-associative tag array for the write-allocate, write-back data
//   cache. It compares the lookup tag against every way of the addressed set,
//   keeps true-LRU ages per set, nominates a replacement victim, and runs an
//   invalidate-all sequencer.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   lookup_index/lookup_tag   set and tag presented for a combinational compare
//   hit, hit_way, hit_dirty   compare result (way and dirty are 0 on a miss)
//   victim_way/_valid/_dirty/_tag
//                             replacement candidate for lookup_index
//   touch                     make hit_way MRU in lookup_index
//   we, wr_index, wr_way, wr_tag, wr_valid, wr_dirty
//                             single-entry write; the written way becomes MRU
//   flush_req                 start invalidate-all
//   busy, flush_done          flush in progress / one-cycle completion pulse
module data_cache_tag_assoc #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int TAG_W = 20,
  localparam int INDEX_W = $clog2(SETS),
  localparam int WAY_W   = $clog2(WAYS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit,
  output logic [WAY_W-1:0]   hit_way,
  output logic               hit_dirty,
  output logic [WAY_W-1:0]   victim_way,
  output logic               victim_valid,
  output logic               victim_dirty,
  output logic [TAG_W-1:0]   victim_tag,
  input  logic               touch,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WAY_W-1:0]   wr_way,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic               flush_req,
  output logic               busy,
  output logic               flush_done
);

  typedef logic [WAYS-1:0][WAY_W-1:0] age_set_t;
  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  age_set_t         age_q  [SETS];

  state_t             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q;

  logic               hit_c;
  logic [WAY_W-1:0]   hit_way_c;
  logic [WAY_W-1:0]   victim_c;
  logic               victim_found;
  logic               wr_ok;
  logic               touch_ok;

  // Way u becomes MRU (age 0); every way younger than u ages by one, so the
  // set's ages remain a permutation of 0..WAYS-1.
  function automatic age_set_t lru_update(input age_set_t a, input logic [WAY_W-1:0] u);
    age_set_t r;
    r = a;
    for (int w = 0; w < WAYS; w++)
      if (a[w] < a[u]) r[w] = a[w] + WAY_W'(1);
    r[u] = '0;
    return r;
  endfunction

  assign busy       = (state_q != IDLE);
  assign flush_done = (state_q == DONE);

  // Scan from the top way down so the lowest matching way wins if several match.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lookup_index][w] && (tag_q[lookup_index][w] == lookup_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
    if (busy) begin
      hit_c     = 1'b0;
      hit_way_c = '0;
    end
  end

  assign hit       = hit_c;
  assign hit_way   = hit_way_c;
  assign hit_dirty = hit_c & dirty_q[lookup_index][hit_way_c];

  // Prefer the lowest invalid way; with a full set fall back to the LRU way.
  always_comb begin
    victim_c     = '0;
    victim_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_found && !valid_q[lookup_index][w]) begin
        victim_c     = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int w = 0; w < WAYS; w++)
        if (age_q[lookup_index][w] == WAY_W'(WAYS - 1)) victim_c = WAY_W'(w);
    end
  end

  assign victim_way   = victim_c;
  assign victim_valid = valid_q[lookup_index][victim_c];
  assign victim_dirty = dirty_q[lookup_index][victim_c];
  assign victim_tag   = tag_q[lookup_index][victim_c];

  // A write to the same set overrides a touch there: only wr_way is aged.
  assign wr_ok    = we && !busy;
  assign touch_ok = touch && hit_c && !(wr_ok && (wr_index == lookup_index));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (cnt_q == INDEX_W'(SETS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)       cnt_q <= '0;
      else if (state_q == FLUSH) cnt_q <= cnt_q + INDEX_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
      end
    end else if (state_q == FLUSH) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      for (int w = 0; w < WAYS; w++) age_q[cnt_q][w] <= WAY_W'(w);
    end else begin
      if (wr_ok) begin
        valid_q[wr_index][wr_way] <= wr_valid;
        dirty_q[wr_index][wr_way] <= wr_dirty;
        age_q[wr_index]           <= lru_update(age_q[wr_index], wr_way);
      end
      if (touch_ok) age_q[lookup_index] <= lru_update(age_q[lookup_index], hit_way_c);
    end
  end

  // Tags carry no reset; an entry's tag is only meaningful while it is valid.
  always_ff @(posedge clock) begin
    if (wr_ok) tag_q[wr_index][wr_way] <= wr_tag;
  end

endmodule
